// File: rtl/mem_rr_arbiter.sv
// Shares one synchronous-read memory between NREQ requesters, with round-robin grants and one operation per cycle.
// Latency: req_ready is combinational with req_valid. Reads return on rsp_valid/rsp_data one cycle after accept.
//          err pulses one cycle after accept. After every reset there are DEPTH clear cycles before the first grant.
// Backpressure: one requester is accepted per cycle. Losers see req_ready=0 and must hold valid and payload stable.
// Ports: clk/rst_n (async, active-low); req_valid/req_ready handshake per requester;
//        req_op/req_addr/req_wdata/req_bit_idx/req_bit_val packed per requester (requester i at slice i);
//        rsp_valid one-hot read strobe, rsp_data shared read data; init_done after clear; err on illegal op/address.
module mem_rr_arbiter #(
    parameter  int NREQ   = 2,
    parameter  int ADDR_W = 4,
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    input  logic [NREQ*BIT_W-1:0]    req_bit_idx,
    input  logic [NREQ-1:0]          req_bit_val,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     init_done,
    output logic                     err
);

    localparam int ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GNT_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WORD = 2'b01;
    localparam logic [1:0] OP_BIT  = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [ROW_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic               clr_we;
    logic               run;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [GNT_W-1:0]   last_grant;
    logic [GNT_W-1:0]   gnt_idx;
    logic               gnt_found;
    logic [NREQ-1:0]    gnt_onehot;
    logic               accept;

    logic [1:0]         sel_op;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [BIT_W-1:0]   sel_bit_idx;
    logic               sel_bit_val;
    logic [ROW_W-1:0]   sel_row;
    logic               in_range;

    // ---------------- init/run FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        run         = 1'b0;
        case (state)
            S_INIT: begin
                clr_we = 1'b1;
                if (clr_cnt == ROW_W'(DEPTH - 1)) begin
                    state_nxt   = S_RUN;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            S_RUN: begin
                run = 1'b1;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    assign init_done = (state == S_RUN);

    // ---------------- round-robin grant ----------------
    // Search starts one past the last winner, so the most recent winner
    // has the lowest priority next cycle.
    always_comb begin
        int cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant) + k) % NREQ;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = GNT_W'(cand);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            gnt_onehot[i] = gnt_found && (int'(gnt_idx) == i);
        end
    end

    assign req_ready = run ? gnt_onehot : '0;
    assign accept    = run && gnt_found;

    // ---------------- winner payload mux ----------------
    always_comb begin
        sel_op      = OP_RD;
        sel_addr    = '0;
        sel_wdata   = '0;
        sel_bit_idx = '0;
        sel_bit_val = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(gnt_idx) == i) begin
                sel_op      = req_op[2*i +: 2];
                sel_addr    = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata   = req_wdata[i*DATA_W +: DATA_W];
                sel_bit_idx = req_bit_idx[i*BIT_W +: BIT_W];
                sel_bit_val = req_bit_val[i];
            end
        end
    end

    assign in_range = (int'(sel_addr) < DEPTH);
    assign sel_row  = ROW_W'(sel_addr);

    // ---------------- memory array ----------------
    // No reset on the array: the INIT sequencer clears it after every reset.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (accept && in_range) begin
            if (sel_op == OP_WORD) begin
                mem[sel_row] <= sel_wdata;
            end else if (sel_op == OP_BIT) begin
                mem[sel_row][sel_bit_idx] <= sel_bit_val;
            end
        end
    end

    // ---------------- response / error registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_W'(NREQ - 1);
            rsp_valid  <= '0;
            rsp_data   <= '0;
            err        <= 1'b0;
        end else begin
            rsp_valid <= '0;
            err       <= 1'b0;
            if (accept) begin
                last_grant <= gnt_idx;
                err        <= (sel_op == OP_ILL) || !in_range;
                if (sel_op == OP_RD) begin
                    rsp_valid <= gnt_onehot;
                    rsp_data  <= in_range ? mem[sel_row] : '0;
                end
            end
        end
    end

endmodule
